nios2_oci_dct_sequencer: RTL and testbench

- Sequences the OCI data-capture-trace (DCT) packing buffer: accepts 2-bit trace atoms, packs them into the 30-bit DCT buffer and tracks the 4-bit DCT count.
- Hands full or flushed buffers to the downstream trace FIFO over a valid/ready handshake.
- Sits between the Nios II OCI data-trace source and the on-chip trace memory. Its live dct_buffer/dct_count outputs feed the OCI test-bench monitor.

---
 rtl/nios2_oci_dct_pkg.sv | 18 +
 rtl/nios2_oci_dct_sequencer_if.sv | 22 ++
 rtl/nios2_oci_dct_outreg.sv | 49 ++++
 rtl/nios2_oci_dct_sequencer.sv | 91 +++++++++
 tb/tb_nios2_oci_dct_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios2_oci_dct_pkg.sv
// Shared constants and state types for the OCI DCT packing sequencer.
package nios2_oci_dct_pkg;

    localparam int unsigned ATOM_W = 2;
    localparam int unsigned SLOTS  = 15;
    localparam int unsigned BUF_W  = ATOM_W * SLOTS;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} fill_state_e;
    typedef enum logic {OUT_IDLE, OUT_VALID} out_state_e;

    function automatic fill_state_e fill_state_of(input logic [CNT_W-1:0] cnt);
        if (cnt == '0) return EMPTY;
        if (cnt == CNT_W'(SLOTS)) return FULL;
        return FILLING;
    endfunction

endpackage

// File: rtl/nios2_oci_dct_sequencer_if.sv
// Atom input and packed-buffer valid/ready output of the DCT sequencer.
interface nios2_oci_dct_sequencer_if;
    import nios2_oci_dct_pkg::*;

    logic              atom_valid;
    logic [ATOM_W-1:0] atom_data;
    logic              out_valid;
    logic              out_ready;
    logic [BUF_W-1:0]  out_buffer;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output atom_valid, atom_data, out_ready,
        input  out_valid, out_buffer, out_count
    );

    modport slave (
        input  atom_valid, atom_data, out_ready,
        output out_valid, out_buffer, out_count
    );

endinterface

// File: rtl/nios2_oci_dct_outreg.sv
// One-entry valid/ready holding register; data stays put while stalled.
module nios2_oci_dct_outreg
    import nios2_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [BUF_W-1:0] load_buffer,
    input  logic [CNT_W-1:0] load_count,
    input  logic             ready,
    output logic             valid,
    output logic [BUF_W-1:0] buffer,
    output logic [CNT_W-1:0] count,
    output logic             slot_free
);

    out_state_e       state_q, state_d;
    logic [BUF_W-1:0] buffer_q;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OUT_IDLE:  if (load) state_d = OUT_VALID;
            // A load while draining keeps the slot occupied with the new buffer.
            OUT_VALID: if (!load && ready) state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= OUT_IDLE;
            buffer_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                buffer_q <= load_buffer;
                count_q  <= load_count;
            end
        end
    end

    assign valid     = (state_q == OUT_VALID);
    assign buffer    = buffer_q;
    assign count     = count_q;
    assign slot_free = !valid || ready;

endmodule

// File: rtl/nios2_oci_dct_sequencer.sv
// Packs 2-bit trace atoms into the 30-bit DCT buffer and hands full or flushed
// buffers to the trace FIFO through a one-entry output register.
module nios2_oci_dct_sequencer
    import nios2_oci_dct_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       overflow_clr,
    nios2_oci_dct_sequencer_if.slave   bus,
    output logic [BUF_W-1:0]           dct_buffer,
    output logic [CNT_W-1:0]           dct_count,
    output logic                       overflow,
    output logic                       busy
);

    fill_state_e      state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d, eff_buf, atom_ext;
    logic [CNT_W-1:0] cnt_q, cnt_d, eff_cnt;
    logic             flush_pend_q, flush_pend_d;
    logic             overflow_q, overflow_d;
    logic             accept, merge, pend, transfer, slot_free;

    always_comb begin
        accept   = enable && bus.atom_valid;
        merge    = accept && (state_q != FULL);
        atom_ext = {{(BUF_W - ATOM_W){1'b0}}, bus.atom_data};
        eff_buf  = buf_q;
        eff_cnt  = cnt_q;
        // Effective contents include an atom accepted this cycle.
        if (merge) begin
            eff_buf = buf_q | (atom_ext << (ATOM_W * cnt_q));
            eff_cnt = cnt_q + CNT_W'(1);
        end
        pend     = flush_pend_q || flush;
        transfer = slot_free && ((eff_cnt == CNT_W'(SLOTS)) || (pend && (eff_cnt != '0)));

        buf_d = eff_buf;
        cnt_d = eff_cnt;
        if (transfer) begin
            // An atom arriving while FULL lands in slot 0 of the freshly cleared register.
            if (accept && (state_q == FULL)) begin
                buf_d = atom_ext;
                cnt_d = CNT_W'(1);
            end else begin
                buf_d = '0;
                cnt_d = '0;
            end
        end
        state_d = fill_state_of(cnt_d);

        flush_pend_d = pend && !transfer && (eff_cnt != '0);
        overflow_d   = (accept && (state_q == FULL) && !transfer) || (overflow_q && !overflow_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= EMPTY;
            buf_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            overflow_q   <= overflow_d;
        end
    end

    nios2_oci_dct_outreg u_outreg (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (transfer),
        .load_buffer (eff_buf),
        .load_count  (eff_cnt),
        .ready       (bus.out_ready),
        .valid       (bus.out_valid),
        .buffer      (bus.out_buffer),
        .count       (bus.out_count),
        .slot_free   (slot_free)
    );

    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign overflow   = overflow_q;
    assign busy       = (cnt_q != '0) || bus.out_valid || flush_pend_q;

endmodule

// File: tb/tb_nios2_oci_dct_sequencer.sv
// Directed scenarios plus randomized traffic checked against an atom-queue model.
module tb_nios2_oci_dct_sequencer;
    import nios2_oci_dct_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic flush = 1'b0;
    logic overflow_clr = 1'b0;
    logic [BUF_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;
    logic overflow;
    logic busy;

    nios2_oci_dct_sequencer_if bus ();

    nios2_oci_dct_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .flush        (flush),
        .overflow_clr (overflow_clr),
        .bus          (bus.slave),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: fill is a list of atoms, output slot holds a list of atoms.
    int m_fill[$];
    int m_out[$];
    bit m_out_valid;
    bit m_pend;
    bit m_ovf;

    function automatic logic [BUF_W-1:0] pack(input int q[$]);
        logic [BUF_W-1:0] r = '0;
        foreach (q[k]) r[ATOM_W*k +: ATOM_W] = ATOM_W'(q[k]);
        return r;
    endfunction

    function automatic void model_reset();
        m_fill.delete();
        m_out.delete();
        m_out_valid = 0;
        m_pend = 0;
        m_ovf = 0;
    endfunction

    function automatic void model_step();
        int  eff[$];
        bit  acc, room, pend, xfer;
        acc  = enable && bus.atom_valid;
        room = m_fill.size() < SLOTS;
        eff  = m_fill;
        if (acc && room) eff.push_back(int'(bus.atom_data));
        pend = m_pend || flush;
        xfer = (!m_out_valid || bus.out_ready) &&
               (eff.size() == SLOTS || (pend && eff.size() > 0));
        m_ovf = (acc && !room && !xfer) || (m_ovf && !overflow_clr);
        m_pend = !xfer && pend && eff.size() > 0;
        if (xfer) begin
            m_out = eff;
            m_out_valid = 1;
            m_fill.delete();
            if (acc && !room) m_fill.push_back(int'(bus.atom_data));
        end else begin
            if (m_out_valid && bus.out_ready) m_out_valid = 0;
            m_fill = eff;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        flush = 1'b0;
        overflow_clr = 1'b0;
        bus.atom_valid = 1'b0;
        bus.atom_data = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic send(input logic [ATOM_W-1:0] a);
        bus.atom_valid = 1'b1;
        bus.atom_data = a;
        tick();
        bus.atom_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (dct_count !== '0 || dct_buffer !== '0 || bus.out_valid !== 1'b0 ||
            bus.out_buffer !== '0 || bus.out_count !== '0 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: cnt=%0d buf=%h ov=%b ob=%h oc=%0d ovf=%b busy=%b, want all 0",
                     dct_count, dct_buffer, bus.out_valid, bus.out_buffer, bus.out_count, overflow, busy);
        end
        enable = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) send(ATOM_W'($urandom_range(3)));
        n_cmp++;
        if (dct_count !== 4'd7 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_prefill: cnt=%0d busy=%b, want 7 1", dct_count, busy);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (dct_count !== '0 || dct_buffer !== '0 || bus.out_valid !== 1'b0 ||
            overflow !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_fill: cnt=%0d buf=%h ov=%b ovf=%b busy=%b, want all 0",
                     dct_count, dct_buffer, bus.out_valid, overflow, busy);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (dct_count !== '0 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: cnt=%0d ov=%b busy=%b, want 0 0 0",
                     dct_count, bus.out_valid, busy);
        end
    endtask

    task automatic test_full_packing();
        logic [BUF_W-1:0] exp = '0;
        do_reset();
        enable = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < SLOTS; k++) begin
            exp[ATOM_W*k +: ATOM_W] = ATOM_W'(k % 4);
            send(ATOM_W'(k % 4));
            if (k == 13) begin
                n_cmp++;
                if (bus.out_valid !== 1'b0 || dct_count !== 4'd14 || dct_buffer !== exp) begin
                    n_bad++;
                    $display("FAIL pack_14: ov=%b cnt=%0d buf=%h, want 0 14 %h",
                             bus.out_valid, dct_count, dct_buffer, exp);
                end
            end
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_count !== 4'd15 || bus.out_buffer !== exp ||
            dct_count !== '0) begin
            n_bad++;
            $display("FAIL pack_full: ov=%b oc=%0d ob=%h cnt=%0d, want 1 15 %h 0",
                     bus.out_valid, bus.out_count, bus.out_buffer, dct_count, exp);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL pack_drain: ov=%b busy=%b, want 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic test_partial_flush();
        do_reset();
        enable = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) send(2'b11);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_count !== 4'd5 || bus.out_buffer !== 30'h3FF ||
            dct_count !== '0) begin
            n_bad++;
            $display("FAIL flush_partial: ov=%b oc=%0d ob=%h cnt=%0d, want 1 5 3ff 0",
                     bus.out_valid, bus.out_count, bus.out_buffer, dct_count);
        end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_empty: ov=%b busy=%b, want 0 0", bus.out_valid, busy);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_empty_after: ov=%b busy=%b, want 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic fill_two(output logic [BUF_W-1:0] b1, output logic [BUF_W-1:0] b2);
        logic [ATOM_W-1:0] a;
        b1 = '0;
        b2 = '0;
        for (int k = 0; k < 2 * SLOTS; k++) begin
            a = ATOM_W'($urandom_range(3));
            if (k < SLOTS) b1[ATOM_W*k +: ATOM_W] = a;
            else b2[ATOM_W*(k-SLOTS) +: ATOM_W] = a;
            send(a);
        end
    endtask

    task automatic test_backpressure();
        logic [BUF_W-1:0] b1, b2, b1_seen;
        int stable_bad = 0;
        do_reset();
        enable = 1'b1;
        fill_two(b1, b2);
        b1_seen = bus.out_buffer;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || b1_seen !== b1 || bus.out_count !== 4'd15) begin
            n_bad++;
            $display("FAIL bp_first_held: ov=%b ob=%h oc=%0d, want 1 %h 15",
                     bus.out_valid, b1_seen, bus.out_count, b1);
        end
        n_cmp++;
        if (dct_count !== 4'd15 || dct_buffer !== b2 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_second_full: cnt=%0d buf=%h ovf=%b, want 15 %h 0",
                     dct_count, dct_buffer, overflow, b2);
        end
        send(ATOM_W'($urandom_range(3)));
        n_cmp++;
        if (overflow !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== b2 ||
            bus.out_buffer !== b1) begin
            n_bad++;
            $display("FAIL bp_drop: ovf=%b cnt=%0d buf=%h ob=%h, want 1 15 %h %h",
                     overflow, dct_count, dct_buffer, bus.out_buffer, b2, b1);
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_buffer !== b2 || bus.out_count !== 4'd15 ||
            dct_count !== '0) begin
            n_bad++;
            $display("FAIL bp_back_to_back: ov=%b ob=%h oc=%0d cnt=%0d, want 1 %h 15 0",
                     bus.out_valid, bus.out_buffer, bus.out_count, dct_count, b2);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_drained: ov=%b ovf=%b, want 0 1", bus.out_valid, overflow);
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_ovf_clr: ovf=%b, want 0", overflow);
        end
        for (int k = 0; k < 3; k++) if (bus.out_valid !== 1'b0) stable_bad++;
        n_cmp++;
        if (stable_bad != 0) begin
            n_bad++;
            $display("FAIL bp_idle: idle_violations=%0d, want 0", stable_bad);
        end
    endtask

    task automatic test_simultaneous();
        logic [BUF_W-1:0] b1, b2;
        logic [ATOM_W-1:0] a;
        do_reset();
        enable = 1'b1;
        fill_two(b1, b2);
        a = ATOM_W'($urandom_range(1, 3));
        bus.out_ready = 1'b1;
        send(a);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_buffer !== b2 || dct_count !== 4'd1 ||
            dct_buffer !== BUF_W'(a) || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_xfer: ov=%b ob=%h cnt=%0d buf=%h ovf=%b, want 1 %h 1 %h 0",
                     bus.out_valid, bus.out_buffer, dct_count, dct_buffer, overflow, b2, a);
        end
    endtask

    task automatic test_enable_gating();
        logic [BUF_W-1:0] b = '0;
        logic [ATOM_W-1:0] a;
        do_reset();
        enable = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = ATOM_W'($urandom_range(3));
            b[ATOM_W*k +: ATOM_W] = a;
            send(a);
        end
        enable = 1'b0;
        for (int k = 0; k < 10; k++) send(ATOM_W'($urandom_range(3)));
        n_cmp++;
        if (dct_count !== 4'd4 || dct_buffer !== b || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL gate_hold: cnt=%0d buf=%h ov=%b, want 4 %h 0",
                     dct_count, dct_buffer, bus.out_valid, b);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_count !== 4'd4 || bus.out_buffer !== b) begin
            n_bad++;
            $display("FAIL gate_flush: ov=%b oc=%0d ob=%h, want 1 4 %h",
                     bus.out_valid, bus.out_count, bus.out_buffer, b);
        end
    endtask

    task automatic test_random();
        bit exp_busy;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(7) != 0);
            bus.atom_valid = ($urandom_range(3) != 0);
            bus.atom_data = ATOM_W'($urandom_range(3));
            bus.out_ready = ((i / 64) % 2 == 1) ? ($urandom_range(5) == 0) : ($urandom_range(2) != 0);
            flush = ($urandom_range(19) == 0);
            overflow_clr = ($urandom_range(24) == 0);
            tick();
            exp_busy = (m_fill.size() != 0) || m_out_valid || m_pend;
            n_cmp++;
            if (dct_count !== CNT_W'(m_fill.size()) || dct_buffer !== pack(m_fill)) begin
                n_bad++;
                $display("FAIL rand_fill[%0d]: cnt=%0d buf=%h, want %0d %h",
                         i, dct_count, dct_buffer, m_fill.size(), pack(m_fill));
            end
            n_cmp++;
            if (bus.out_valid !== m_out_valid || overflow !== m_ovf || busy !== exp_busy) begin
                n_bad++;
                $display("FAIL rand_flags[%0d]: ov=%b ovf=%b busy=%b, want %b %b %b",
                         i, bus.out_valid, overflow, busy, m_out_valid, m_ovf, exp_busy);
            end
            if (m_out_valid) begin
                n_cmp++;
                if (bus.out_count !== CNT_W'(m_out.size()) || bus.out_buffer !== pack(m_out)) begin
                    n_bad++;
                    $display("FAIL rand_out[%0d]: oc=%0d ob=%h, want %0d %h",
                             i, bus.out_count, bus.out_buffer, m_out.size(), pack(m_out));
                end
            end
        end
        bus.atom_valid = 1'b0;
        flush = 1'b0;
        overflow_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_packing();
        test_partial_flush();
        test_backpressure();
        test_simultaneous();
        test_enable_gating();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
